// File: rtl/video_pkg.sv
// Shared video timing types: FSM states, the measured timing-set record and
// default counter widths common to the receive and output timing blocks.
package video_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int POS_W_DEF = 11;
  // Record fields are sized for the widest supported counter; narrower
  // counters are zero-extended into them.
  localparam int TSET_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } vt_state_e;

  typedef struct packed {
    logic [TSET_W-1:0] h_total;
    logic [TSET_W-1:0] h_active;
    logic [TSET_W-1:0] v_total;
    logic [TSET_W-1:0] v_active;
  } tset_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop register of a sync/qualifier input with rising and falling edge
// pulses aligned to the first registered copy.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic d_p1;
  logic d_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_p1 <= 1'b0;
      d_p2 <= 1'b0;
    end else begin
      d_p1 <= d;
      d_p2 <= d_p1;
    end
  end

  assign q    = d_p1;
  assign rise = d_p1 & ~d_p2;
  assign fall = ~d_p1 & d_p2;

endmodule

// File: rtl/video_timing_rx.sv
// Receive-side video timing recovery: registered pixel stream with x/y
// coordinates, line/frame size measurement and lock detection.
module video_timing_rx
  import video_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_hs,
  input  logic              video_vs,
  input  logic              video_de,
  input  logic [DATA_W-1:0] data_in,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [POS_W-1:0]  pixel_xpos,
  output logic [POS_W-1:0]  pixel_ypos,
  output logic              frame_start,
  output logic [CNT_W-1:0]  h_total,
  output logic [CNT_W-1:0]  h_active,
  output logic [CNT_W-1:0]  v_total,
  output logic [CNT_W-1:0]  v_active,
  output logic              locked,
  output logic              fmt_err
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [POS_W-1:0] pos_sat_inc(input logic [POS_W-1:0] v);
    return (v == POS_MAX) ? v : v + 1'b1;
  endfunction

  // ---- stage 1: input registers and edge detection ----
  logic hs_p1, hs_rise, hs_fall;
  logic vs_p1, vs_rise, vs_fall;
  logic de_p1, de_rise, de_fall;
  logic [DATA_W-1:0] data_p1;
  logic unused_sync;

  sync_edge_det u_hs_det (
    .clk(pixel_clk), .rst_n(sys_rst_n), .d(video_hs),
    .q(hs_p1), .rise(hs_rise), .fall(hs_fall)
  );

  sync_edge_det u_vs_det (
    .clk(pixel_clk), .rst_n(sys_rst_n), .d(video_vs),
    .q(vs_p1), .rise(vs_rise), .fall(vs_fall)
  );

  sync_edge_det u_de_det (
    .clk(pixel_clk), .rst_n(sys_rst_n), .d(video_de),
    .q(de_p1), .rise(de_rise), .fall(de_fall)
  );

  assign unused_sync = ^{hs_p1, hs_fall, vs_p1, vs_fall};

  always_ff @(posedge pixel_clk) begin
    data_p1 <= data_in;
  end

  // ---- stage 2: registered pixel stream and coordinates ----
  logic [POS_W-1:0] x_cnt;
  logic [POS_W-1:0] y_cnt;
  logic             first_pend;
  logic             fs_fire;

  // A de run already in progress across the vs edge does not re-arm the marker.
  assign fs_fire = vs_rise ? de_rise : (de_p1 & first_pend);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      first_pend  <= 1'b0;
    end else begin
      pix_valid   <= de_p1;
      pix_data    <= data_p1;
      pixel_xpos  <= x_cnt;
      pixel_ypos  <= vs_rise ? '0 : y_cnt;
      frame_start <= fs_fire;
      first_pend  <= vs_rise ? ~de_p1 : (first_pend & ~de_p1);
      x_cnt       <= de_p1 ? pos_sat_inc(x_cnt) : '0;
      if (vs_rise) begin
        y_cnt <= '0;
      end else if (de_fall) begin
        y_cnt <= pos_sat_inc(y_cnt);
      end
    end
  end

  // ---- line / frame measurement ----
  logic [CNT_W-1:0] hcnt, decnt, lcnt, alcnt;
  logic [CNT_W-1:0] ht_last, ha_cur;
  logic             ha_set, incons;
  logic             line_de, de_line_end;
  logic [CNT_W-1:0] ha_eff, va_eff, ht_eff, lcnt_nxt;
  logic             incons_eff;
  logic             hcnt_ovf, lcnt_ovf, ovf;
  tset_t            new_set;
  logic             new_cons;
  logic             frm_done;

  // The line closing on this cycle's hs edge still belongs to the old frame.
  assign line_de     = (decnt != '0);
  assign de_line_end = hs_rise & line_de;
  assign ha_eff      = ha_set ? ha_cur : (de_line_end ? decnt : '0);
  assign incons_eff  = incons | (de_line_end & ha_set & (decnt != ha_cur));
  assign va_eff      = de_line_end ? cnt_sat_inc(alcnt) : alcnt;
  assign ht_eff      = hs_rise ? hcnt : ht_last;

  always_comb begin
    lcnt_nxt = lcnt;
    if (vs_rise) begin
      lcnt_nxt = CNT_W'(hs_rise);
    end else if (hs_rise) begin
      lcnt_nxt = cnt_sat_inc(lcnt);
    end
  end

  assign hcnt_ovf = ~hs_rise & (hcnt == CNT_PRE);
  assign lcnt_ovf = hs_rise & ~vs_rise & (lcnt == CNT_PRE);
  assign ovf      = hcnt_ovf | lcnt_ovf;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt     <= '0;
      decnt    <= '0;
      lcnt     <= '0;
      alcnt    <= '0;
      ht_last  <= '0;
      ha_cur   <= '0;
      ha_set   <= 1'b0;
      incons   <= 1'b0;
      new_set  <= '0;
      new_cons <= 1'b0;
      frm_done <= 1'b0;
    end else begin
      hcnt     <= hs_rise ? CNT_W'(1) : cnt_sat_inc(hcnt);
      lcnt     <= lcnt_nxt;
      frm_done <= vs_rise;
      if (hs_rise) begin
        ht_last <= hcnt;
        decnt   <= CNT_W'(de_p1);
      end else if (de_p1) begin
        decnt <= cnt_sat_inc(decnt);
      end
      if (vs_rise) begin
        new_set.h_total  <= TSET_W'(ht_eff);
        new_set.h_active <= TSET_W'(ha_eff);
        new_set.v_total  <= TSET_W'(lcnt);
        new_set.v_active <= TSET_W'(va_eff);
        new_cons         <= ~incons_eff;
        alcnt            <= '0;
        ha_cur           <= '0;
        ha_set           <= 1'b0;
        incons           <= 1'b0;
      end else if (de_line_end) begin
        alcnt <= cnt_sat_inc(alcnt);
        if (!ha_set) begin
          ha_set <= 1'b1;
          ha_cur <= decnt;
        end else if (decnt != ha_cur) begin
          incons <= 1'b1;
        end
      end
    end
  end

  // ---- lock FSM ----
  vt_state_e       state, state_nxt;
  logic [MC_W-1:0] match_cnt, match_nxt, match_inc;
  tset_t           stored_set;
  logic            set_eq, store_set, load_out, locked_nxt, err_nxt;

  assign set_eq    = new_cons & (match_cnt != '0) & (new_set == stored_set);
  assign match_inc = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 1'b1;

  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    store_set  = 1'b0;
    load_out   = 1'b0;
    locked_nxt = locked;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_rise) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (vs_rise) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (set_eq) begin
          match_nxt = match_inc;
        end else begin
          store_set = 1'b1;
          match_nxt = MC_W'(1);
        end
        if (match_nxt >= LOCK_N) begin
          state_nxt  = ST_LOCKED;
          load_out   = 1'b1;
          locked_nxt = 1'b1;
        end else begin
          state_nxt = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (frm_done && !set_eq) begin
          state_nxt  = ST_MEASURE;
          locked_nxt = 1'b0;
          err_nxt    = 1'b1;
          store_set  = 1'b1;
          match_nxt  = MC_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Counter overflow abandons the frame regardless of where the FSM is.
    if (ovf) begin
      state_nxt  = ST_IDLE;
      locked_nxt = 1'b0;
      err_nxt    = 1'b1;
      match_nxt  = '0;
      store_set  = 1'b0;
      load_out   = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      stored_set <= '0;
      locked     <= 1'b0;
      fmt_err    <= 1'b0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      locked    <= locked_nxt;
      fmt_err   <= err_nxt;
      if (store_set) stored_set <= new_set;
      if (load_out) begin
        h_total  <= new_set.h_total[CNT_W-1:0];
        h_active <= new_set.h_active[CNT_W-1:0];
        v_total  <= new_set.v_total[CNT_W-1:0];
        v_active <= new_set.v_active[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: pixel scoreboard plus lock, format
// change, inconsistent line, overflow and mid-frame reset sequences.
module tb_video_timing_rx;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;
  localparam int POS_W  = 11;
  localparam int HT     = 20;
  localparam int VT     = 10;
  localparam int VA     = 6;

  logic              pixel_clk;
  logic              sys_rst_n;
  logic              video_hs, video_vs, video_de;
  logic [DATA_W-1:0] data_in;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic [POS_W-1:0]  pixel_xpos, pixel_ypos;
  logic              frame_start;
  logic [CNT_W-1:0]  h_total, h_active, v_total, v_active;
  logic              locked, fmt_err;

  video_timing_rx #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .POS_W(POS_W), .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .data_in(data_in),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .fmt_err(fmt_err)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [POS_W-1:0]  x;
    logic [POS_W-1:0]  y;
    logic              fs;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   err_seen = 0;

  always @(negedge pixel_clk) begin
    if (fmt_err === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_xpos"}, 32'(pixel_xpos), 0);
    chk({tag, "_ypos"}, 32'(pixel_ypos), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_h_total"}, 32'(h_total), 0);
    chk({tag, "_h_active"}, 32'(h_active), 0);
    chk({tag, "_v_total"}, 32'(v_total), 0);
    chk({tag, "_v_active"}, 32'(v_active), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_fmt_err"}, 32'(fmt_err), 0);
  endtask

  // Drive one cycle of input with its expected output; outputs lag by 2 cycles.
  task automatic tick(input logic hs, input logic vs, input logic de,
                      input logic [DATA_W-1:0] d, input logic fs, input int x, input int y);
    exp_t e;
    exp_t o;
    @(posedge pixel_clk);
    #1;
    video_hs = hs;
    video_vs = vs;
    video_de = de;
    data_in  = d;
    e.v  = de;
    e.d  = d;
    e.x  = x[POS_W-1:0];
    e.y  = y[POS_W-1:0];
    e.fs = fs;
    sbq.push_back(e);
    @(negedge pixel_clk);
    if (sbq.size() >= 3) begin
      o = sbq.pop_front();
      chk("pix_valid", 32'(pix_valid), 32'(o.v));
      chk("frame_start", 32'(frame_start), 32'(o.fs));
      if (o.v) begin
        chk("pix_data", 32'(pix_data), 32'(o.d));
        chk("pixel_xpos", 32'(pixel_xpos), 32'(o.x));
        chk("pixel_ypos", 32'(pixel_ypos), 32'(o.y));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
  endtask

  // One frame: hs/vs pulse 2 cycles wide, active lines 2..7, active columns from 4.
  task automatic run_frame(input int ha, input int bad_line, input int bad_ha,
                           input logic exp_lock, input int exp_ha, input int abort_at);
    for (int l = 0; l < VT; l++) begin
      for (int h = 0; h < HT; h++) begin
        int   lha;
        logic de;
        lha = (l == bad_line) ? bad_ha : ha;
        de  = (l >= 2) && (l < 2 + VA) && (h >= 4) && (h < 4 + lha);
        tick(h < 2, (l == 0) && (h < 2), de, 16'($urandom), (l == 2) && (h == 4), h - 4, l - 2);
        if (l == 0 && h == 10) begin
          chk("locked", 32'(locked), 32'(exp_lock));
          if (exp_lock) begin
            chk("h_total", 32'(h_total), HT);
            chk("h_active", 32'(h_active), 32'(exp_ha));
            chk("v_total", 32'(v_total), VT);
            chk("v_active", 32'(v_active), VA);
          end
        end
        if (l * HT + h == abort_at) return;
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    video_hs  = 1'b0;
    video_vs  = 1'b0;
    video_de  = 1'b0;
    data_in   = '0;
    repeat (5) @(posedge pixel_clk);
    #1;
    chk_all_zero("reset");
    sys_rst_n = 1'b1;

    // Quiet input: nothing moves.
    idle(100);
    chk("idle_locked", 32'(locked), 0);
    chk("idle_fmt_err_count", 32'(err_seen), 0);
    chk("idle_h_total", 32'(h_total), 0);

    // Stable 20/12/10/6 format: lock on the 3rd vs edge.
    run_frame(12, -1, 0, 1'b0, 12, -1);
    run_frame(12, -1, 0, 1'b0, 12, -1);
    run_frame(12, -1, 0, 1'b1, 12, -1);
    run_frame(12, -1, 0, 1'b1, 12, -1);
    chk("stable_fmt_err_count", 32'(err_seen), 0);

    // Format change to h_active 8 while locked.
    run_frame(8, -1, 0, 1'b1, 12, -1);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    chk("change_fmt_err_count", 32'(err_seen), 1);
    run_frame(8, -1, 0, 1'b1, 8, -1);

    // One line with 11 de cycles breaks lock at that frame's end.
    run_frame(8, 4, 11, 1'b1, 8, -1);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    chk("incons_fmt_err_count", 32'(err_seen), 2);
    run_frame(8, -1, 0, 1'b1, 8, -1);

    // hs held low long enough to saturate hcnt.
    idle(4200);
    chk("ovf_fmt_err_count", 32'(err_seen), 3);
    chk("ovf_locked", 32'(locked), 0);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    run_frame(8, -1, 0, 1'b1, 8, -1);
    chk("post_ovf_fmt_err_count", 32'(err_seen), 3);

    // Reset while locked at pixel (5,3): line 5, column 9.
    run_frame(8, -1, 0, 1'b1, 8, 5 * HT + 9);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sbq.delete();
    video_hs = 1'b0;
    video_vs = 1'b0;
    video_de = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(30);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_h_active", 32'(h_active), 0);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    run_frame(8, -1, 0, 1'b0, 8, -1);
    run_frame(8, -1, 0, 1'b1, 8, -1);
    chk("final_fmt_err_count", 32'(err_seen), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_rx.md
# video_timing_rx

Receive-side video timing recovery for the pixel pipeline, the counterpart to the HDMI output timing generator. It takes a raw hs/vs/de/pixel stream, for example from the sensor path or a loop-back, and regenerates per-pixel x/y coordinates and a registered pixel stream. It measures total and active line/frame sizes and declares lock after consecutive identical frames. Downstream, the SDRAM write path and the ISP stages use its coordinates, frame-start marker and lock flag.

## Interface
Parameters:
- DATA_W, 16, pixel data width
- CNT_W, 12, width of all timing counters and measurement outputs
- POS_W, 11, width of pixel_xpos / pixel_ypos
- LOCK_FRAMES, 2, consecutive identical frames required for lock (≥1)

Ports:
- pixel_clk  in  1  sole clock; all logic on rising edge
- sys_rst_n  in  1  reset; asynchronous, active-low
- video_hs  in  1  line sync, active-high; rising edge = line start
- video_vs  in  1  frame sync, active-high; rising edge = frame start
- video_de  in  1  active-video qualifier
- data_in  in  DATA_W  pixel data, valid when video_de=1
- pix_valid  out  1  registered, delayed video_de
- pix_data  out  DATA_W  registered data_in
- pixel_xpos  out  POS_W  column of the current pix_valid pixel
- pixel_ypos  out  POS_W  active-line index of the current pixel
- frame_start  out  1  one-cycle pulse on the first pix_valid pixel of a frame
- h_total, h_active, v_total, v_active  out  CNT_W each  last locked measurement
- locked  out  1  timing stable
- fmt_err  out  1  one-cycle pulse on a measurement mismatch or counter overflow

## Operation
- **Input register.** All inputs are registered once (stage 1). Rising edges of hs/vs are detected against a second registered copy of each.
- **Line measurement.**
  - hcnt counts clocks and restarts to 1 on each hs rising edge.
  - The value before restart is the line's h_total.
  - decnt counts de-high clocks per line.
  - The first line of a frame with decnt>0 sets the frame's h_active.
  - Any later de-line with a different decnt marks the frame inconsistent.
- **Frame measurement.**
  - lcnt counts hs rising edges between vs rising edges; that count gives v_total.
  - alcnt counts lines with decnt>0; that count gives v_active.
- **Coordinates.**
  - pixel_xpos increments per pix_valid pixel and returns to 0 on the de falling edge.
  - pixel_ypos increments on each de falling edge and returns to 0 on the vs rising edge.
  - Both saturate at 2^POS_W−1.
- **FSM states:**
  - IDLE: wait for the first vs rising edge, then go to MEASURE.
  - MEASURE: accumulate one full frame; at the next vs rising edge go to CHECK.
  - CHECK (1 cycle):
    - If the frame is consistent and the 4 values equal the stored set, increment match_cnt.
    - Otherwise store the new set and set match_cnt=1.
    - If match_cnt reaches LOCK_FRAMES, go to LOCKED and copy the set to the outputs; else go to MEASURE.
  - LOCKED: keep measuring. At each frame end a mismatch or inconsistency causes: locked←0, a fmt_err pulse, store the new set, match_cnt=1, go to MEASURE.
- **Overflow.** hcnt or lcnt reaching 2^CNT_W−1 saturates, pulses fmt_err once, and forces IDLE with locked=0.
- **Independence.** pix_valid / pix_data / coordinates are produced whether or not locked is set. Consumers gate on locked.

## Timing
- **Reset values:**
  - All outputs 0: pix_valid, pix_data, pixel_xpos, pixel_ypos, frame_start, the four measurements, locked, fmt_err.
  - FSM in IDLE, match_cnt=0.
- **Latency:**
  - pix_valid / pix_data / pixel_xpos / pixel_ypos appear exactly 2 cycles after video_de / data_in.
  - frame_start is aligned with its pixel.
- **Lock timing.**
  - locked rises 1 cycle after the vs rising edge that closes the LOCK_FRAMES-th matching frame (CHECK cycle).
  - Measurement outputs update in that same cycle.
- **vs and hs in the same cycle.** The edge counts as both frame start and line start. The new line is line 0 of the new frame.
- **de high across a vs edge.** The pixel belongs to the new frame. xpos continues, ypos resets to 0, frame_start is not re-pulsed.
- **Frame with no de-lines.** h_active=v_active=0; this is treated as a valid set.
- **Reset mid-frame.** Everything clears asynchronously and the block waits in IDLE for the next vs edge. The partial frame is never measured.

## Structure
- Shared package (video_pkg): the FSM state enum, the timing-set record (h_total, h_active, v_total, v_active), and the CNT_W/POS_W defaults shared with the output timing generator.
- One natural sub-module: `sync_edge_det` (2-flop register plus rising/falling pulse), instantiated for hs, vs and de.

## Test plan
- **Reset, no input:** hold hs/vs/de low for 100 cycles → all outputs 0, locked=0.
- **Small stable format:** h_total 20, h_active 12, v_total 10, v_active 6, LOCK_FRAMES=2.
  - Required: locked=1 one cycle after the 3rd vs edge, outputs 20/12/10/6.
  - xpos runs 0..11, ypos runs 0..5, and pixels lag by 2 cycles.
- **Format change while locked:** switch h_active to 8.
  - Required: at frame end fmt_err pulses once and locked→0.
  - Relock with h_active=8 after 2 further frames.
- **Inconsistent line:** one line in a frame with 11 de cycles → no lock for that frame; match_cnt restarts.
- **Overflow:** hs held low for 4095 cycles → fmt_err pulse, FSM in IDLE, locked=0.
- **Reset mid-frame:** assert sys_rst_n=0 while locked at pixel (5,3) → all outputs 0 immediately, and relock takes 2 full frames after release.
